exmem_mem_stage: RTL and testbench

- EX/MEM pipeline register plus MEM-stage control for the 8-bit RISC pipeline.
- Latches EX results and drives a req/ack data-memory port for loads and stores.
- Stalls upstream stages while a memory access is outstanding.
- Presents regwrite/mem_to_reg/read-data/ALU-result/rd directly to the MEM/WB register inputs. Inserts bubbles (regwrite=0) while stalled.

---
 rtl/exmem_mem_stage.sv | 128 ++++++++++++
 tb/tb_exmem_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exmem_mem_stage.sv
// EX/MEM pipeline register plus MEM-stage control for the 8-bit RISC pipeline.
// Memory ops sit in REQ until the data memory acks. While they wait, upstream
// stages are stalled and a bubble goes to MEM/WB. The DONE cycle then releases
// the write-back.
module exmem_mem_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              regwrite_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [RD_W-1:0]   rd_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              regwrite_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [RD_W-1:0]   rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                valid_q, regwrite_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [DATA_W-1:0]   alu_q, store_q, rdata_q, rdata_d;
  logic [RD_W-1:0]     rd_q;
  logic                load_en;

  // Upstream advances whenever no access is outstanding.
  assign load_en = (state_q != REQ);

  // EX/MEM register: capture EX results whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      rd_q         <= '0;
    end else if (load_en) begin
      valid_q      <= valid_in;
      regwrite_q   <= regwrite_in;
      mem_read_q   <= mem_read_in;
      mem_write_q  <= mem_write_in;
      mem_to_reg_q <= mem_to_reg_in;
      alu_q        <= alu_result_in;
      store_q      <= store_data_in;
      rd_q         <= rd_in;
    end
  end

  // State and captured load data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and captured-data update. An ack only counts while in REQ.
  // A store with the read bit also set stays a store, so its ack does not
  // touch rdata_q.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (mem_read_q && !mem_write_q) rdata_d = mem_rdata;
        end
      end
      default: begin
        // IDLE and DONE both load the next instruction, so back-to-back
        // memory ops chain directly.
        state_d = (valid_in && (mem_read_in || mem_write_in)) ? REQ : IDLE;
      end
    endcase
  end

  // Memory port and MEM/WB-facing outputs.
  always_comb begin
    stall_out      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    regwrite_out   = valid_q & regwrite_q;
    mem_to_reg_out = mem_to_reg_q;
    read_data_out  = rdata_q;
    alu_result_out = alu_q;
    rd_out         = rd_q;
    case (state_q)
      REQ: begin
        // Request fields come straight from held registers, so they stay
        // stable until the ack arrives.
        stall_out    = 1'b1;
        mem_req      = 1'b1;
        mem_we       = mem_write_q;
        mem_addr     = alu_q[ADDR_W-1:0];
        mem_wdata    = store_q;
        regwrite_out = 1'b0;
      end
      DONE: regwrite_out = regwrite_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exmem_mem_stage.sv
// Directed bench for exmem_mem_stage. Inputs change 1 time unit after the
// rising edge, and the outputs are checked at that point.
module tb_exmem_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in, regwrite_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic [7:0] alu_result_in, store_data_in;
  logic [2:0] rd_in;
  logic       stall_out, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic       regwrite_out, mem_to_reg_out;
  logic [7:0] read_data_out, alu_result_out;
  logic [2:0] rd_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  exmem_mem_stage dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .regwrite_in(regwrite_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .rd_in(rd_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .regwrite_out(regwrite_out), .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [7:0] alu, input logic [7:0] sd,
                       input logic [2:0] rd);
    valid_in = v; regwrite_in = rw; mem_read_in = mr; mem_write_in = mw;
    mem_to_reg_in = m2r; alu_result_in = alu; store_data_in = sd; rd_in = rd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
  endtask

  initial begin
    // Reset held for 2 cycles while the inputs carry random values.
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom_range(1), $urandom_range(1), $urandom_range(1),
            $urandom_range(1), 8'($urandom), 8'($urandom), 3'($urandom));
      mem_ack = 1'($urandom_range(1)); mem_rdata = 8'($urandom);
      tick();
    end
    chk("rst_stall",  stall_out, 0);
    chk("rst_req",    mem_req, 0);
    chk("rst_we",     mem_we, 0);
    chk("rst_addr",   mem_addr, 0);
    chk("rst_wdata",  mem_wdata, 0);
    chk("rst_rw",     regwrite_out, 0);
    chk("rst_m2r",    mem_to_reg_out, 0);
    chk("rst_rdata",  read_data_out, 0);
    chk("rst_alu",    alu_result_out, 0);
    chk("rst_rd",     rd_out, 0);
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    bubble();
    tick();
    chk("idle_req", mem_req, 0);

    // ALU op: no added latency.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 3'd3);
    tick();
    chk("alu_rw",    regwrite_out, 1);
    chk("alu_res",   alu_result_out, 8'h5A);
    chk("alu_rd",    rd_out, 3);
    chk("alu_stall", stall_out, 0);
    chk("alu_req",   mem_req, 0);

    // Load to 0x10. The ack arrives in the third REQ cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd5);
    tick();
    bubble();
    for (int c = 0; c < 3; c++) begin
      chk("ld_req",   mem_req, 1);
      chk("ld_we",    mem_we, 0);
      chk("ld_addr",  mem_addr, 8'h10);
      chk("ld_stall", stall_out, 1);
      chk("ld_rw",    regwrite_out, 0);
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 8'hC3; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("ld_done_rw",    regwrite_out, 1);
    chk("ld_done_m2r",   mem_to_reg_out, 1);
    chk("ld_done_data",  read_data_out, 8'hC3);
    chk("ld_done_rd",    rd_out, 5);
    chk("ld_done_req",   mem_req, 0);
    chk("ld_done_stall", stall_out, 0);

    // Store 0x77 to 0x20 with an immediate ack. An ALU op (0x33 -> r2)
    // waits behind the store.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd0);
    tick();
    chk("st_req",   mem_req, 1);
    chk("st_we",    mem_we, 1);
    chk("st_addr",  mem_addr, 8'h20);
    chk("st_wdata", mem_wdata, 8'h77);
    chk("st_stall", stall_out, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 3'd2);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    chk("st_done_rw",    regwrite_out, 0);
    chk("st_done_req",   mem_req, 0);
    chk("st_done_stall", stall_out, 0);
    chk("st_rdata_held", read_data_out, 8'hC3);
    tick();
    chk("after_st_rw",  regwrite_out, 1);
    chk("after_st_alu", alu_result_out, 8'h33);
    chk("after_st_rd",  rd_out, 2);

    // Back-to-back loads: 0x01 -> r1, then 0x02 -> r2.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd1);
    tick();
    chk("b2b1_req",  mem_req, 1);
    chk("b2b1_addr", mem_addr, 8'h01);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 3'd2);
    mem_ack = 1'b1; mem_rdata = 8'hA1;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("b2b1_rw",   regwrite_out, 1);
    chk("b2b1_rd",   rd_out, 1);
    chk("b2b1_data", read_data_out, 8'hA1);
    tick();
    bubble();
    chk("b2b2_req",  mem_req, 1);
    chk("b2b2_addr", mem_addr, 8'h02);
    chk("b2b2_rw",   regwrite_out, 0);
    mem_ack = 1'b1; mem_rdata = 8'hB2;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("b2b2_rw_done", regwrite_out, 1);
    chk("b2b2_rd",      rd_out, 2);
    chk("b2b2_data",    read_data_out, 8'hB2);
    tick();
    chk("b2b_idle_rw", regwrite_out, 0);

    // A spurious ack in IDLE must leave the captured data alone.
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk("spur_data", read_data_out, 8'hB2);
    chk("spur_req",  mem_req, 0);

    // A bubble that carries mem_read never issues a request.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00, 3'd6);
    tick();
    chk("bub_req", mem_req, 0);
    chk("bub_rw",  regwrite_out, 0);

    // With read and write both set, the access is a store.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h50, 8'h66, 3'd0);
    tick();
    bubble();
    chk("rw_both_we", mem_we, 1);
    mem_ack = 1'b1; mem_rdata = 8'hDD;
    tick();
    mem_ack = 1'b0;
    chk("rw_both_data", read_data_out, 8'hB2);
    tick();

    // A reset during REQ abandons the access with no write-back.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 3'd4);
    tick();
    chk("rstreq_req", mem_req, 1);
    bubble();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstreq_req_drop", mem_req, 0);
    chk("rstreq_rw",       regwrite_out, 0);
    chk("rstreq_stall",    stall_out, 0);
    chk("rstreq_data",     read_data_out, 0);
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    tick();
    mem_ack = 1'b0;
    chk("rstreq_no_wb", regwrite_out, 0);
    chk("rstreq_spur",  read_data_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
